// File: rtl/score_board.sv
// Air-hockey scoring engine: per-player BCD goal counters, win detection with
// one-hot winner, and a time-multiplexed common-anode seven-segment scan.
module score_board #(
   parameter int NUM_PLAYERS  = 2,
   parameter int DIGITS       = 2,
   parameter int WIN_SCORE    = 7,
   parameter int REFRESH_DIV  = 25000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PLAYERS-1:0]          goal,
   input  logic                            clear,
   output logic [NUM_PLAYERS*DIGITS*4-1:0] score_bcd,
   output logic                            game_over,
   output logic [NUM_PLAYERS-1:0]          winner,
   output logic [NUM_PLAYERS*DIGITS-1:0]   an,
   output logic [7:0]                      seg
);

   localparam int N     = NUM_PLAYERS * DIGITS;
   localparam int SW    = DIGITS * 4;
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   function automatic logic [SW-1:0] to_bcd(input int value);
      logic [SW-1:0] r;
      int            v;
      r = '0;
      v = value;
      for (int d = 0; d < DIGITS; d++) begin
         r[d*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   localparam logic [SW-1:0] WIN_BCD   = to_bcd(WIN_SCORE);
   localparam logic [SW-1:0] ALL_NINES = to_bcd(10**DIGITS - 1);

   // Ripple-carry BCD increment that sticks at all nines instead of wrapping.
   function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
      logic [SW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      if (v == ALL_NINES) return v;
      for (int d = 0; d < DIGITS; d++) begin
         if (carry) begin
            if (r[d*4 +: 4] == 4'd9) begin
               r[d*4 +: 4] = 4'd0;
            end else begin
               r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'h7F;
      endcase
   endfunction

   logic [NUM_PLAYERS-1:0] goal_q;
   logic [NUM_PLAYERS-1:0] point;
   logic [N*4-1:0]         score_q, score_d;
   logic                   over_q, over_d;
   logic [NUM_PLAYERS-1:0] winner_q, winner_d;
   logic [SW-1:0]          inc;

   // ---------------------------------------------------------------------
   // Scoring
   // ---------------------------------------------------------------------
   // NOTE: every variable written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      point    = goal & ~goal_q;
      score_d  = score_q;
      over_d   = over_q;
      winner_d = winner_q;
      inc      = '0;
      if (clear) begin
         score_d  = '0;
         over_d   = 1'b0;
         winner_d = '0;
      end else if (!over_q) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (point[p]) begin
               inc                   = bcd_inc(score_q[p*SW +: SW]);
               score_d[p*SW +: SW]   = inc;
               if (inc == WIN_BCD) begin
                  winner_d[p] = 1'b1;
                  over_d      = 1'b1;
               end
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of process order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         goal_q   <= '0;
         score_q  <= '0;
         over_q   <= 1'b0;
         winner_q <= '0;
      end else begin
         goal_q   <= goal;
         score_q  <= score_d;
         over_q   <= over_d;
         winner_q <= winner_d;
      end
   end

   assign score_bcd = score_q;
   assign game_over = over_q;
   assign winner    = winner_q;

   // ---------------------------------------------------------------------
   // Display scan and blink
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] scan_cnt;
   logic [IDX_W-1:0] digit_idx;
   logic [BLK_W-1:0] blink_cnt;
   logic             blink_phase;
   logic             scan_step;
   logic             frame_wrap;
   logic [N-1:0]     an_q;
   logic [7:0]       seg_q;
   logic [7:0]       glyph [N];
   logic [3:0]       dig;
   logic             lead;

   assign scan_step  = (scan_cnt == CNT_W'(REFRESH_DIV - 1));
   assign frame_wrap = scan_step && (digit_idx == IDX_W'(N - 1));

   // Glyph for every digit position; lead tracks "all higher digits are zero".
   always_comb begin
      dig  = '0;
      lead = 1'b1;
      for (int i = 0; i < N; i++) glyph[i] = 8'hFF;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         lead = 1'b1;
         for (int d = DIGITS - 1; d >= 0; d--) begin
            dig  = score_q[(p*DIGITS + d)*4 +: 4];
            lead = lead & (dig == 4'd0);
            if (over_q && blink_phase && winner_q[p]) begin
               glyph[p*DIGITS + d] = 8'hFF;
            end else begin
               glyph[p*DIGITS + d][7]   = !((d == 0) && (p > 0));
               glyph[p*DIGITS + d][6:0] = ((d > 0) && lead) ? 7'h7F : seg7(dig);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
         an_q      <= '1;
         seg_q     <= 8'hFF;
      end else begin
         scan_cnt <= scan_step ? '0 : scan_cnt + CNT_W'(1);
         if (scan_step) begin
            digit_idx <= frame_wrap ? '0 : digit_idx + IDX_W'(1);
            an_q      <= ~(N'(1) << digit_idx);
            seg_q     <= glyph[digit_idx];
         end
      end
   end

   // Blink counts whole frames only while the game is over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (clear) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (!over_q) begin
         blink_cnt <= '0;
      end else if (frame_wrap) begin
         if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
         end
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_score_board.sv
// Randomized bench for score_board: integer-score reference model predicts
// scores, win/game-over and every scanned display word cycle by cycle.
module tb_score_board;

   localparam int NP  = 2;
   localparam int DG  = 2;
   localparam int WIN = 23;
   localparam int RD  = 4;
   localparam int BF  = 1;
   localparam int N   = NP * DG;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NP-1:0]     goal = '0;
   logic              clear = 1'b0;
   logic [N*4-1:0]    score_bcd;
   logic              game_over;
   logic [NP-1:0]     winner;
   logic [N-1:0]      an;
   logic [7:0]        seg;

   score_board #(
      .NUM_PLAYERS (NP),
      .DIGITS      (DG),
      .WIN_SCORE   (WIN),
      .REFRESH_DIV (RD),
      .BLINK_FRAMES(BF)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .goal     (goal),
      .clear    (clear),
      .score_bcd(score_bcd),
      .game_over(game_over),
      .winner   (winner),
      .an       (an),
      .seg      (seg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: scores as plain integers, display from step arithmetic.
   int            m_score [NP];
   bit            m_over;
   bit [NP-1:0]   m_win;
   bit [NP-1:0]   m_gq;
   int            m_cyc;
   int            m_wraps;
   logic [N-1:0]  m_an;
   logic [7:0]    m_seg;

   function automatic int pow10(input int d);
      int r = 1;
      for (int i = 0; i < d; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [6:0] glyph7(input int v);
      logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return tab[v];
   endfunction

   function automatic logic [N*4-1:0] exp_bcd();
      logic [N*4-1:0] r = '0;
      for (int p = 0; p < NP; p++)
         for (int d = 0; d < DG; d++)
            r[(p*DG + d)*4 +: 4] = 4'((m_score[p] / pow10(d)) % 10);
      return r;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) m_score[p] = 0;
      m_over  = 0;
      m_win   = '0;
      m_gq    = '0;
      m_cyc   = 0;
      m_wraps = 0;
      m_an    = '1;
      m_seg   = 8'hFF;
   endtask

   task automatic model_edge(input logic [NP-1:0] g, input logic clr);
      bit          wrap;
      bit          new_over;
      bit [NP-1:0] pnt;
      int          i, p, d;
      wrap = 0;
      m_cyc++;
      if (m_cyc % RD == 0) begin
         i = (m_cyc / RD - 1) % N;
         p = i / DG;
         d = i % DG;
         m_an    = '1;
         m_an[i] = 1'b0;
         if (m_over && ((m_wraps / BF) % 2 == 1) && m_win[p]) begin
            m_seg = 8'hFF;
         end else begin
            m_seg[7]   = (d == 0 && p > 0) ? 1'b0 : 1'b1;
            m_seg[6:0] = (d > 0 && m_score[p] < pow10(d)) ? 7'h7F
                         : glyph7((m_score[p] / pow10(d)) % 10);
         end
         wrap = (i == N - 1);
      end
      if (clr || !m_over) m_wraps = 0;
      else if (wrap) m_wraps++;
      pnt  = g & ~m_gq;
      m_gq = g;
      if (clr) begin
         for (int q = 0; q < NP; q++) m_score[q] = 0;
         m_over = 0;
         m_win  = '0;
      end else if (!m_over) begin
         new_over = 0;
         for (int q = 0; q < NP; q++) begin
            if (pnt[q] && m_score[q] < pow10(DG) - 1) begin
               m_score[q]++;
               if (m_score[q] == WIN) begin
                  m_win[q] = 1'b1;
                  new_over = 1;
               end
            end
         end
         m_over = new_over;
      end
   endtask

   task automatic compare_all();
      check("score_bcd", score_bcd, exp_bcd());
      check("game_over", game_over, m_over);
      check("winner", winner, m_win);
      check("an", an, m_an);
      check("seg", seg, m_seg);
   endtask

   task automatic tick(input logic [NP-1:0] g, input logic clr);
      goal  = g;
      clear = clr;
      @(posedge clk);
      model_edge(g, clr);
      #1;
      compare_all();
   endtask

   task automatic pulse(input logic [NP-1:0] g, input int count);
      for (int k = 0; k < count; k++) begin
         tick(g, 1'b0);
         tick('0, 1'b0);
      end
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [NP-1:0] g;
      logic          c;
      model_reset();
      #12;
      compare_all();
      rst_n = 1'b1;

      pulse(2'b01, 3);
      pulse(2'b10, 1);
      check("plan_0103", score_bcd, 16'h0103);

      tick(2'b01, 1'b0);
      for (int k = 0; k < 100; k++) tick(2'b01, 1'b0);
      tick(2'b00, 1'b0);
      tick(2'b00, 1'b1);

      pulse(2'b01, 12);
      for (int k = 0; k < 20; k++) tick(2'b00, 1'b0);
      tick(2'b00, 1'b1);

      pulse(2'b11, WIN);
      check("tie_winner", winner, 2'b11);
      for (int k = 0; k < 40; k++) tick(2'b00, 1'b0);
      tick(2'b00, 1'b1);

      pulse(2'b10, WIN);
      check("p1_winner", winner, 2'b10);
      for (int k = 0; k < 70; k++) tick(2'b00, 1'b0);
      async_reset();
      for (int k = 0; k < 10; k++) tick(2'b00, 1'b0);

      g = '0;
      for (int k = 0; k < 15000; k++) begin
         for (int p = 0; p < NP; p++)
            if ($urandom_range(0, 2) == 0) g[p] = ~g[p];
         c = m_over ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 2999) == 0);
         tick(g, c);
         if ($urandom_range(0, 4999) == 0) async_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/score_board.md
# score_board

Parametrised scoring and seven-segment display engine for the air-hockey game, replacing the fixed two-player, two-digit score path between the game logic and the display. It counts goals per player in BCD, detects the winning score and latches game-over with a one-hot winner, and time-multiplexes all score digits onto one common-anode seven-segment bank. On game-over the winner's digits blink. Everything runs on the single game clock.

## Interface
Parameters:
- NUM_PLAYERS, 2, number of players, 1..4
- DIGITS, 2, BCD digits per player, 1..3
- WIN_SCORE, 7, decimal score that ends the game; must be below 10^DIGITS
- REFRESH_DIV, 25000, clk cycles per digit scan step, ≥2
- BLINK_FRAMES, 64, full scan frames per blink half-period, ≥1

Ports:
- clk, input, 1, game clock; all state on rising edge
- rst_n, input, 1, asynchronous active-low reset
- goal, input, NUM_PLAYERS, level per player; each rising edge scores one point
- clear, input, 1, synchronous score/game clear
- score_bcd, output, NUM_PLAYERS*DIGITS*4, player p digit d at bits [(p*DIGITS+d)*4 +: 4]; d=0 is ones
- game_over, output, 1, win latched
- winner, output, NUM_PLAYERS, one-hot (multi-hot on tie) winning players
- an, output, NUM_PLAYERS*DIGITS, active-low digit enables
- seg, output, 8, active-low {dp,g,f,e,d,c,b,a}

## Operation
- Reset (async, rst_n=0): score_bcd=0, game_over=0, winner=0, goal history=0, scan counter=0, digit index=0, blink phase=0, an=all 1s, seg=8'hFF.
- Goal edge: goal_q registers goal; point[p] = goal[p] & ~goal_q[p]. A level held high scores once.
- Score update: on point[p], increment player p BCD with carry ripple (9→0, carry to next digit). At all-9s it saturates and does not wrap.
- Simultaneous points for different players all apply in the same cycle.
- Win: if a player's post-increment score equals WIN_SCORE, set winner[p] and game_over in that same cycle. Tie in one cycle sets multiple winner bits.
- While game_over=1, points are ignored and scores freeze. goal_q still tracks goal.
- clear=1: scores, game_over, winner and blink phase go to 0. goal_q still loads goal. clear overrides a same-cycle point.
- Scan: counter counts 0..REFRESH_DIV-1. On wrap, digit index advances 0..N-1 and wraps, with N=NUM_PLAYERS*DIGITS.
- Display register load on each scan step: an = ~(1<<index). seg[6:0] = decode of score digit at that index.
- Decode values: 0→7'b1000000, 1→7'b1111001, 7→7'b1111000, 8→7'b0000000, 9→7'b0010000.
- Leading-zero blanking: a non-ones digit that is 0 with all higher digits of the same player 0 gives seg[6:0]=7'h7F.
- dp (seg[7]) is 0 only on the ones digit of players p>0, as a separator; otherwise 1.
- Blink: count index wraps. After BLINK_FRAMES wraps, toggle blink phase and restart the count. The count runs only while game_over=1 and holds 0 otherwise. When game_over=1 and phase=1, digits of winner players drive seg=8'hFF, with an unchanged.

## Timing
- Goal first high at edge n: score_bcd, game_over and winner update at edge n. Visible one cycle after goal is sampled.
- Display latency: new score appears on seg when its digit is next scanned, at most N*REFRESH_DIV cycles later.
- First scan step fires REFRESH_DIV cycles after reset release. an/seg stay blank until then.
- Reset mid-scan or mid-blink returns immediately to the reset values; no partial frame is retained.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset then goal[0] pulses 3×, goal[1] pulses 1× (defaults) → score_bcd=16'h0103; game_over=0.
- goal[0] held high for 100 cycles → exactly one point; score_bcd[3:0] goes 0→1 one cycle after the rise.
- DIGITS=2, WIN_SCORE=99 → score 09 + point → 10 (carry); at 99 game_over=1 and winner=01; further goals leave 99.
- Both players at 6, simultaneous goal edges (WIN_SCORE=7) → both 7, winner=2'b11, game_over=1; clear in the next cycle → all zero, game_over=0.
- REFRESH_DIV=4, scores P0=5, P1=12 → an cycles 1110,1101,1011,0111 every 4 cycles; seg = 5 on digit 0, blank on digit 1 (leading zero), 2 with dp=0 on digit 2, 1 on digit 3.
- REFRESH_DIV=4, BLINK_FRAMES=1, P1 wins → P1 digits alternate blank/lit each 16-cycle frame; P0 digits always lit; rst_n pulse mid-frame → an=all 1s immediately.
